// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned FETCH_COUNT_WIDTH = 16;

  // Fetch control state: BOOT inserts one bubble after reset, RUN fetches.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  // MIPS nop (sll $0,$0,0) used as the bubble instruction.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Default start of the text segment.
  localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: clear (bubble) beats enable (hold when low).
module if_id_register
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pcplus4_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pcplus4_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
  logic                  valid_q, valid_d;

  // Next contents: bubble on clear, new instruction on enable, else hold.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (clear) begin
      instr_d   = DATA_WIDTH'(NOP);
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (enable) begin
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end
  end

  // Register update with asynchronous clear to a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q   <= DATA_WIDTH'(NOP);
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule : if_id_register

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect mux, IF/ID register, fetch counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(DEFAULT_TEXT_BASE),
  parameter int unsigned           MEMORY_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Stall,
  input  logic                         Flush,
  input  logic                         BranchTaken,
  input  logic [DATA_WIDTH-1:0]        BranchTarget,
  input  logic [DATA_WIDTH-1:0]        Instruction_i,
  output logic [DATA_WIDTH-1:0]        MemAddress_o,
  output logic [DATA_WIDTH-1:0]        PC_o,
  output logic [DATA_WIDTH-1:0]        IF_ID_Instruction_o,
  output logic [DATA_WIDTH-1:0]        IF_ID_PCPlus4_o,
  output logic                         IF_ID_Valid_o,
  output logic [FETCH_COUNT_WIDTH-1:0] FetchCount_o
);

  fsm_state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]        pc_q, pc_d;
  logic [FETCH_COUNT_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0]        pc_plus4_c;
  logic                         ifid_clear_c;
  logic                         pc_in_text_c;
  logic                         unused_ok_c;

  assign pc_plus4_c   = pc_q + DATA_WIDTH'(4);
  assign MemAddress_o = pc_q - TEXT_BASE;

  // Out-of-range fetch proceeds unchanged; the window flag is informational only.
  assign pc_in_text_c = (MemAddress_o < DATA_WIDTH'(4 * MEMORY_DEPTH));
  assign unused_ok_c  = ^{BranchTarget[1:0], pc_in_text_c};

  // Next state, next PC, IF/ID clear and fetch count.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    ifid_clear_c = 1'b0;
    case (state_q)
      BOOT: begin
        state_d      = RUN;
        pc_d         = TEXT_BASE;
        ifid_clear_c = 1'b1;
      end
      RUN: begin
        if (BranchTaken) begin
          pc_d = {BranchTarget[DATA_WIDTH-1:2], 2'b00};
        end else if (!Stall) begin
          pc_d = pc_plus4_c;
        end
        ifid_clear_c = Flush | BranchTaken;
        if (!ifid_clear_c && !Stall) begin
          count_d = count_q + FETCH_COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d      = BOOT;
        ifid_clear_c = 1'b1;
      end
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= TEXT_BASE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign PC_o         = pc_q;
  assign FetchCount_o = count_q;

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .enable    (~Stall),
    .clear     (ifid_clear_c),
    .instr_i   (Instruction_i),
    .pcplus4_i (pc_plus4_c),
    .instr_o   (IF_ID_Instruction_o),
    .pcplus4_o (IF_ID_PCPlus4_o),
    .valid_o   (IF_ID_Valid_o)
  );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle reference model plus directed literal checks.
module tb_fetch_stage;

  localparam logic [31:0] TB_BASE = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction_i;
  logic [31:0] MemAddress_o;
  logic [31:0] PC_o;
  logic [31:0] IF_ID_Instruction_o;
  logic [31:0] IF_ID_PCPlus4_o;
  logic        IF_ID_Valid_o;
  logic [15:0] FetchCount_o;

  int n_tests;
  int n_fail;

  fetch_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .Stall               (Stall),
    .Flush               (Flush),
    .BranchTaken         (BranchTaken),
    .BranchTarget        (BranchTarget),
    .Instruction_i       (Instruction_i),
    .MemAddress_o        (MemAddress_o),
    .PC_o                (PC_o),
    .IF_ID_Instruction_o (IF_ID_Instruction_o),
    .IF_ID_PCPlus4_o     (IF_ID_PCPlus4_o),
    .IF_ID_Valid_o       (IF_ID_Valid_o),
    .FetchCount_o        (FetchCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: word i holds 0x20080001 + i*0x00010001, 32 words, address wraps.
  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    logic [31:0] idx;
    idx = (byte_addr >> 2) & 32'd31;
    return 32'h2008_0001 + idx * 32'h0001_0001;
  endfunction

  assign Instruction_i = mem_word(MemAddress_o);

  // Reference model of the architectural fetch behaviour.
  logic        m_boot;
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_v;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_boot <= 1'b1;
      m_pc   <= TB_BASE;
      m_ins  <= 32'h0;
      m_p4   <= 32'h0;
      m_v    <= 1'b0;
      m_cnt  <= 16'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_ins  <= 32'h0;
      m_p4   <= 32'h0;
      m_v    <= 1'b0;
    end else begin
      m_pc <= BranchTaken ? (BranchTarget & ~32'd3) : (Stall ? m_pc : m_pc + 32'd4);
      if (Flush || BranchTaken) begin
        m_ins <= 32'h0;
        m_p4  <= 32'h0;
        m_v   <= 1'b0;
      end else if (!Stall) begin
        m_ins <= mem_word(m_pc - TB_BASE);
        m_p4  <= m_pc + 32'd4;
        m_v   <= 1'b1;
        m_cnt <= m_cnt + 16'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("m_pc",    PC_o,                 m_pc);
      chk("m_addr",  MemAddress_o,         m_pc - TB_BASE);
      chk("m_instr", IF_ID_Instruction_o,  m_ins);
      chk("m_pc4",   IF_ID_PCPlus4_o,      m_p4);
      chk("m_valid", 32'(IF_ID_Valid_o),   32'(m_v));
      chk("m_count", {16'h0, FetchCount_o}, {16'h0, m_cnt});
    end
  endtask

  // One clock edge with the given controls; returns just after the edge.
  task automatic cyc(input logic s, input logic f, input logic b, input logic [31:0] t);
    @(negedge clk);
    #1;
    Stall        = s;
    Flush        = f;
    BranchTaken  = b;
    BranchTarget = t;
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Release reset with quiet controls and return just after the BOOT edge.
  task automatic release_reset();
    @(negedge clk);
    #1;
    Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] ins, input logic [31:0] p4,
                          input logic v);
    chk({name, "_instr"}, IF_ID_Instruction_o, ins);
    chk({name, "_pc4"},   IF_ID_PCPlus4_o,     p4);
    chk({name, "_valid"}, 32'(IF_ID_Valid_o),  32'(v));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", PC_o, 32'h0040_0000);
    chk("rst_addr", MemAddress_o, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_count", {16'h0, FetchCount_o}, 32'h0);

    // Sequential fetch: BOOT bubble, then three instructions in order
    release_reset();
    chk("boot_valid", 32'(IF_ID_Valid_o), 32'h0);
    chk("boot_pc", PC_o, 32'h0040_0000);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_ifid("seq0", 32'h2008_0001, 32'h0040_0004, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_ifid("seq2", 32'h200A_0003, 32'h0040_000C, 1'b1);
    chk("seq_count", {16'h0, FetchCount_o}, 32'd3);
    chk("seq_pc", PC_o, 32'h0040_000C);

    // Stall two edges at PC 0x00400008
    assert_reset();
    release_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_stall_pc", PC_o, 32'h0040_0008);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_pc", PC_o, 32'h0040_0008);
    chk_ifid("stall", 32'h2009_0002, 32'h0040_0008, 1'b1);
    chk("stall_count", {16'h0, FetchCount_o}, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_stall_pc", PC_o, 32'h0040_000C);

    // Flush only at PC 0x0040000C
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("flush_pc", PC_o, 32'h0040_0010);
    chk_ifid("flush", 32'h0, 32'h0, 1'b0);
    chk("flush_count", {16'h0, FetchCount_o}, 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_ifid("post_flush", 32'h200C_0005, 32'h0040_0014, 1'b1);
    chk("post_flush_pc", PC_o, 32'h0040_0014);

    // Reset mid-run with Stall and a redirect pending
    @(negedge clk);
    #1;
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0040_0040;
    #2 reset = 1'b0;
    #1;
    chk("midrst_pc", PC_o, 32'h0040_0000);
    chk("midrst_addr", MemAddress_o, 32'h0);
    chk_ifid("midrst", 32'h0, 32'h0, 1'b0);
    chk("midrst_count", {16'h0, FetchCount_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_hold_pc", PC_o, 32'h0040_0000);
    release_reset();
    chk("reboot_valid", 32'(IF_ID_Valid_o), 32'h0);
    chk("reboot_pc", PC_o, 32'h0040_0000);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_ifid("refetch", 32'h2008_0001, 32'h0040_0004, 1'b1);

    // Branch with stall: redirect wins, target aligned, bubble
    cyc(1'b1, 1'b0, 1'b1, 32'h0040_0023);
    chk("br_pc", PC_o, 32'h0040_0020);
    chk("br_addr", MemAddress_o, 32'h0000_0020);
    chk("br_valid", 32'(IF_ID_Valid_o), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_ifid("br_fetch", 32'h2010_0009, 32'h0040_0024, 1'b1);

    // Flush with stall: PC held, IF/ID bubble
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("fs_pc", PC_o, 32'h0040_0024);
    chk("fs_valid", 32'(IF_ID_Valid_o), 32'h0);

    // PC+4 wrap at the top of the address space
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("top_pc", PC_o, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", PC_o, 32'h0);
    chk_ifid("wrap", 32'h2027_0020, 32'h0, 1'b1);

    // Fetch counter wrap after 0xFFFF valid fetches
    assert_reset();
    release_reset();
    repeat (65535) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("cnt_full", {16'h0, FetchCount_o}, 32'h0000_FFFF);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("cnt_wrap", {16'h0, FetchCount_o}, 32'h0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DATA_WIDTH, 32, instruction and PC width
- TEXT_BASE, 32'h0040_0000, byte address of the first instruction
- MEMORY_DEPTH, 32, program memory depth in words
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock; rising edge
- reset, in, 1, asynchronous, active-low reset
- Stall, in, 1, hold PC and IF/ID contents (load-use hazard)
- Flush, in, 1, load a bubble into IF/ID
- BranchTaken, in, 1, redirect PC to BranchTarget
- BranchTarget, in, DATA_WIDTH, redirect byte address
- Instruction_i, in, DATA_WIDTH, combinational instruction word returned by program memory
- MemAddress_o, out, DATA_WIDTH, byte address to program memory, equal to PC - TEXT_BASE
- PC_o, out, DATA_WIDTH, current fetch PC
- IF_ID_Instruction_o, out, DATA_WIDTH, registered instruction
- IF_ID_PCPlus4_o, out, DATA_WIDTH, registered PC+4 of that instruction
- IF_ID_Valid_o, out, 1, registered instruction is real, not a bubble
- FetchCount_o, out, 16, count of valid instructions written into IF/ID

Function
REQ-003 MemAddress_o SHALL be combinational: PC minus TEXT_BASE, modulo 2^DATA_WIDTH.
REQ-004 The FSM SHALL have two states, BOOT and RUN. Reset SHALL force BOOT. BOOT SHALL go to RUN on the first clock edge, unconditionally.
REQ-005 In BOOT, PC SHALL stay at TEXT_BASE and IF/ID SHALL load a bubble, so the first valid instruction appears one cycle after reset deasserts.
REQ-006 In RUN, per rising edge, the PC update SHALL use this priority, highest first:
- BranchTaken: PC <= {BranchTarget[DATA_WIDTH-1:2], 2'b00}
- Stall: PC held
- otherwise: PC <= PC + 4
REQ-007 In RUN, per rising edge, the IF/ID update SHALL use this priority, highest first:
- Flush or BranchTaken: bubble
- Stall: held
- otherwise: Instruction_i, PC+4, Valid=1
REQ-008 A bubble SHALL be: Instruction=0 (MIPS nop), PCPlus4=0, Valid=0.
REQ-009 When BranchTaken and Stall are asserted together, the redirect SHALL win and IF/ID SHALL take a bubble.
REQ-010 When Flush is asserted without BranchTaken, the PC SHALL still follow REQ-006.
REQ-011 PC+4 SHALL wrap modulo 2^DATA_WIDTH with no flag.
REQ-012 If PC leaves [TEXT_BASE, TEXT_BASE+4*MEMORY_DEPTH), fetch SHALL continue unchanged; the out-of-range contents are the memory's responsibility.
REQ-013 FetchCount_o SHALL increment only on an edge that writes Valid=1 into IF/ID, and SHALL wrap from 16'hFFFF to 0.
REQ-014 Latency: an instruction at PC SHALL appear on IF_ID_*_o exactly one edge after PC_o shows it, with no stall.

Reset
REQ-015 While reset is low, all outputs SHALL hold these values, asynchronously:
- PC_o = TEXT_BASE
- MemAddress_o = 0
- IF_ID_Instruction_o = 0
- IF_ID_PCPlus4_o = 0
- IF_ID_Valid_o = 0
- FetchCount_o = 0
- FSM = BOOT
REQ-016 Reset asserted mid-operation SHALL discard any pending redirect or stall with no residual state.
REQ-017 Reset SHALL act only on the reset port; synchronous inputs SHALL have no effect while reset is low.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, the NOP constant (32'h0000_0000) and the default TEXT_BASE.
REQ-019 The IF/ID register SHALL be one sub-module, if_id_register, with: reset, enable (= not Stall), and synchronous clear (= Flush or BranchTaken or BOOT).
REQ-020 The PC register, adder, redirect mux and FetchCount counter SHALL live in fetch_stage.

Verification
REQ-021 Scenario, sequential fetch: release reset, 4 cycles, memory holding 0x20080001, 0x20090002, ... -> IF_ID_Valid_o=0 in BOOT, then instructions in order with PCPlus4 0x00400004, 0x00400008, ...; FetchCount_o=3.
REQ-022 Scenario, stall: Stall high for 2 cycles at PC=0x00400008 -> PC_o and IF/ID outputs frozen for 2 edges; FetchCount_o unchanged.
REQ-023 Scenario, branch with stall: BranchTaken=1, BranchTarget=0x00400023, Stall=1 -> next PC_o=0x00400020, MemAddress_o=0x20, IF_ID_Valid_o=0.
REQ-024 Scenario, flush only: Flush=1 at PC=0x0040000C -> PC_o=0x00400010, IF/ID bubble, FetchCount_o unchanged.
REQ-025 Scenario, reset mid-run: reset low at PC=0x00400014 with Stall=1 -> immediately PC_o=0x00400000 and all IF/ID outputs 0; after release, BOOT bubble then fetch from 0x00400000.
REQ-026 Scenario, counter wrap: preload FetchCount to 16'hFFFF, one valid fetch -> FetchCount_o=0.
